// File: rtl/mesh_pkt_pkg.sv
// Shared definitions for the mesh terminal transmitter.
// Contents: router packet field widths, the packet assembly helper mk_pkt() and the
// transmit FSM state type.
// Packet layout (MSB..LSB): next-jump[8] = 0 | row[4] | col[4] | mode[1] | payload.
package mesh_pkt_pkg;

  localparam int unsigned NXT_W     = 8;
  localparam int unsigned ROW_W     = 4;
  localparam int unsigned COL_W     = 4;
  // Width of the routing mode field (single bit just above the payload).
  localparam int unsigned MODE_BIT  = 1;
  localparam int unsigned HDR_W     = NXT_W + ROW_W + COL_W + MODE_BIT;
  // Widest packet mk_pkt() can build; callers slice the low pckg_sz bits.
  localparam int unsigned PKT_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    GAP
  } tx_state_e;

  // Builds a packet of pckg_sz bits, right-aligned in a PKT_MAX_W word.
  // Next-jump is left as zero because nothing above the row field is set.
  function automatic logic [PKT_MAX_W-1:0] mk_pkt(input logic [ROW_W-1:0]     row,
                                                  input logic [COL_W-1:0]     col,
                                                  input logic                 mode,
                                                  input logic [PKT_MAX_W-1:0] payload,
                                                  input int unsigned          pckg_sz);
    logic [PKT_MAX_W-1:0] pld_mask;
    logic [PKT_MAX_W-1:0] pkt;
    pld_mask = (64'd1 << (pckg_sz - HDR_W)) - 64'd1;
    pkt = (64'(row)  << (pckg_sz - NXT_W - ROW_W))
        | (64'(col)  << (pckg_sz - NXT_W - ROW_W - COL_W))
        | (64'(mode) << (pckg_sz - HDR_W))
        | (payload & pld_mask);
    return pkt;
  endfunction

endpackage

// File: rtl/mesh_term_tx_if.sv
// Host/router signal bundle for mesh_term_tx.
// Host side:   push, in_row, in_col, in_mode, in_payload -> full, count, overflow, sent_cnt
// Router side: data_out_i_in, pndng_i_in -> popin
// slave is the transmitter's view, master is the driver's view.
interface mesh_term_tx_if #(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned cnt_w      = 16
);

  logic                            push;
  logic [3:0]                      in_row;
  logic [3:0]                      in_col;
  logic                            in_mode;
  logic [pckg_sz-18:0]             in_payload;
  logic                            full;
  logic [$clog2(fifo_depth):0]     count;
  logic [pckg_sz-1:0]              data_out_i_in;
  logic                            pndng_i_in;
  logic                            popin;
  logic                            overflow;
  logic [cnt_w-1:0]                sent_cnt;

  modport slave (
    input  push, in_row, in_col, in_mode, in_payload, popin,
    output full, count, data_out_i_in, pndng_i_in, overflow, sent_cnt
  );

  modport master (
    output push, in_row, in_col, in_mode, in_payload, popin,
    input  full, count, data_out_i_in, pndng_i_in, overflow, sent_cnt
  );

endinterface

// File: rtl/mesh_tx_fifo.sv
// Synchronous request FIFO for mesh_term_tx.
// Ports: clk_i, rst_i (async, active-high); push_i/wdata_i write; pop_i retires the head;
// full_o, empty_o, count_o status; head_o is the oldest entry, second_o the one behind it
// (lets the reader present back-to-back packets without a bubble).
// A push while full is accepted only when pop_i frees a slot in the same cycle.
module mesh_tx_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 40
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           wdata_i,
  input  logic                       pop_i,
  output logic                       full_o,
  output logic                       empty_o,
  output logic [$clog2(Depth):0]     count_o,
  output logic [Width-1:0]           head_o,
  output logic [Width-1:0]           second_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_nxt;
  logic [CntW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == CntW'(Depth));
  assign empty_o = (count_q == '0);
  assign do_pop  = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rd_nxt  = rd_ptr_q + 1'b1;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop)  rd_ptr_d = rd_nxt;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: only entries covered by count_q are ever consumed.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign count_o  = count_q;
  assign head_o   = mem_q[rd_ptr_q];
  assign second_o = mem_q[rd_nxt];

endmodule

// File: rtl/mesh_term_tx.sv
// Terminal-side transmitter for one mesh router input port.
// Ports: clk, reset (async, active-high), bus (mesh_term_tx_if.slave).
// Host requests are assembled into router packets on the write side of a FIFO. The read
// side presents the head on data_out_i_in/pndng_i_in and retires it when popin is seen
// while pndng_i_in is high. With gap_cyc > 0 the valid line drops for exactly gap_cyc
// cycles after every retire. Also tracks a sticky overflow flag and a sent-packet counter.
module mesh_term_tx
  import mesh_pkt_pkg::*;
#(
  parameter int unsigned pckg_sz    = 40,
  parameter int unsigned fifo_depth = 4,
  parameter int unsigned gap_cyc    = 0,
  parameter int unsigned cnt_w      = 16
) (
  input logic          clk,
  input logic          reset,
  mesh_term_tx_if.slave bus
);

  localparam int unsigned CntW = $clog2(fifo_depth) + 1;
  localparam int unsigned GapW = 4;

  logic [PKT_MAX_W-1:0] pkt_full;
  logic [pckg_sz-1:0]   pkt_in;
  logic [pckg_sz-1:0]   head, second, next_head;
  logic [CntW-1:0]      fifo_count;
  logic                 fifo_full, fifo_empty;
  logic                 pop, has_next;

  tx_state_e            state_q, state_d;
  logic                 pndng_q, pndng_d;
  logic [pckg_sz-1:0]   data_q, data_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [cnt_w-1:0]     sent_q, sent_d;
  logic                 overflow_q, overflow_d;

  assign pkt_full = mk_pkt(bus.in_row, bus.in_col, bus.in_mode, 64'(bus.in_payload), pckg_sz);
  assign pkt_in   = pkt_full[pckg_sz-1:0];

  if (pckg_sz < PKT_MAX_W) begin : g_pkt_hi
    logic unused_pkt_hi;
    assign unused_pkt_hi = ^pkt_full[PKT_MAX_W-1:pckg_sz];
  end

  // Retire only while the packet is actually offered; popin in IDLE/GAP is ignored.
  assign pop = (state_q == SEND) && bus.popin;

  mesh_tx_fifo #(
    .Depth (fifo_depth),
    .Width (pckg_sz)
  ) u_fifo (
    .clk_i    (clk),
    .rst_i    (reset),
    .push_i   (bus.push),
    .wdata_i  (pkt_in),
    .pop_i    (pop),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (fifo_count),
    .head_o   (head),
    .second_o (second)
  );

  // After a retire the new head is either the entry behind the current one or, when the
  // last entry leaves, the request being written in the same cycle.
  assign has_next  = (fifo_count >= CntW'(2)) || bus.push;
  assign next_head = (fifo_count >= CntW'(2)) ? second : pkt_in;

  always_comb begin
    state_d    = state_q;
    pndng_d    = pndng_q;
    data_d     = data_q;
    gap_d      = gap_q;
    sent_d     = sent_q + cnt_w'(pop);
    overflow_d = overflow_q | (bus.push && fifo_full && !pop);
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          state_d = SEND;
          pndng_d = 1'b1;
          data_d  = head;
        end
      end
      SEND: begin
        if (bus.popin) begin
          if (gap_cyc != 0) begin
            state_d = GAP;
            pndng_d = 1'b0;
            gap_d   = GapW'(gap_cyc - 1);
          end else if (has_next) begin
            data_d = next_head;
          end else begin
            state_d = IDLE;
            pndng_d = 1'b0;
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          if (!fifo_empty) begin
            state_d = SEND;
            pndng_d = 1'b1;
            data_d  = head;
          end else begin
            state_d = IDLE;
          end
        end else begin
          gap_d = gap_q - 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        pndng_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      pndng_q    <= 1'b0;
      data_q     <= '0;
      gap_q      <= '0;
      sent_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pndng_q    <= pndng_d;
      data_q     <= data_d;
      gap_q      <= gap_d;
      sent_q     <= sent_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.full          = fifo_full;
  assign bus.count         = fifo_count;
  assign bus.data_out_i_in = data_q;
  assign bus.pndng_i_in    = pndng_q;
  assign bus.overflow      = overflow_q;
  assign bus.sent_cnt      = sent_q;

endmodule

// File: tb/tb_mesh_term_tx.sv
// Bench for mesh_term_tx: a gap_cyc=0 instance checked through a scoreboard (expected
// packets queued at push time, compared by a monitor on every retire), plus a gap_cyc=3
// instance for inter-packet gap timing.
module tb_mesh_term_tx;

  localparam int unsigned PckgSz = 40;
  localparam int unsigned PldW   = PckgSz - 17;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mesh_term_tx_if #(.pckg_sz(PckgSz), .fifo_depth(4), .cnt_w(16)) bus ();
  mesh_term_tx_if #(.pckg_sz(PckgSz), .fifo_depth(4), .cnt_w(16)) gbus ();

  mesh_term_tx #(
    .pckg_sz    (PckgSz),
    .fifo_depth (4),
    .gap_cyc    (0),
    .cnt_w      (16)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  mesh_term_tx #(
    .pckg_sz    (PckgSz),
    .fifo_depth (4),
    .gap_cyc    (3),
    .cnt_w      (16)
  ) dut_gap (
    .clk   (clk),
    .reset (reset),
    .bus   (gbus)
  );

  int n_checks = 0;
  int n_errors = 0;
  logic [PckgSz-1:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [PckgSz-1:0] pkt(input logic [3:0] r, input logic [3:0] c,
                                            input logic m, input logic [PldW-1:0] p);
    return {8'h00, r, c, m, p};
  endfunction

  // Called at posedge+1; drives one request for a single cycle.
  task automatic do_push(input logic [3:0] r, input logic [3:0] c, input logic m,
                         input logic [PldW-1:0] p, input bit accept, input bit with_pop);
    bus.push       = 1'b1;
    bus.in_row     = r;
    bus.in_col     = c;
    bus.in_mode    = m;
    bus.in_payload = p;
    bus.popin      = with_pop;
    if (accept) exp_q.push_back(pkt(r, c, m, p));
    @(posedge clk); #1;
    bus.push  = 1'b0;
    bus.popin = 1'b0;
  endtask

  // Scoreboard monitor: a retire happens at the coming edge whenever pndng and popin are high.
  always @(negedge clk) begin
    if (!reset && bus.pndng_i_in && bus.popin) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL retire_unexpected: got %0h expected no packet", bus.data_out_i_in);
      end else begin
        logic [PckgSz-1:0] e;
        e = exp_q.pop_front();
        check("retire_data", 64'(bus.data_out_i_in), 64'(e));
      end
    end
  end

  initial begin
    int zeros;
    bit seen;
    logic [PckgSz-1:0] pa, pb;

    reset = 1'b0;
    bus.push = 1'b0; bus.in_row = '0; bus.in_col = '0; bus.in_mode = 1'b0;
    bus.in_payload = '0; bus.popin = 1'b0;
    gbus.push = 1'b0; gbus.in_row = '0; gbus.in_col = '0; gbus.in_mode = 1'b0;
    gbus.in_payload = '0; gbus.popin = 1'b0;

    // Reset values
    #1 reset = 1'b1;
    #1;
    check("rst_pndng", 64'(bus.pndng_i_in), 64'd0);
    check("rst_data", 64'(bus.data_out_i_in), 64'd0);
    check("rst_full", 64'(bus.full), 64'd0);
    check("rst_count", 64'(bus.count), 64'd0);
    check("rst_overflow", 64'(bus.overflow), 64'd0);
    check("rst_sent", 64'(bus.sent_cnt), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Single packet and latency
    do_push(4'd0, 4'd3, 1'b0, 23'd3, 1'b1, 1'b0);
    check("lat_pndng_early", 64'(bus.pndng_i_in), 64'd0);
    check("lat_count", 64'(bus.count), 64'd1);
    @(posedge clk); #1;
    check("single_pndng", 64'(bus.pndng_i_in), 64'd1);
    check("single_data", 64'(bus.data_out_i_in), 64'h0003000003);
    bus.popin = 1'b1;
    @(posedge clk); #1;
    bus.popin = 1'b0;
    check("single_done_pndng", 64'(bus.pndng_i_in), 64'd0);
    check("single_sent", 64'(bus.sent_cnt), 64'd1);
    check("single_count", 64'(bus.count), 64'd0);

    // Fill and overflow: fifth push is dropped
    for (int i = 0; i < 5; i++) begin
      do_push(4'(i), 4'(3 - i), 1'(i), 23'(16'h0100 + i), i < 4, 1'b0);
    end
    check("fill_full", 64'(bus.full), 64'd1);
    check("fill_count", 64'(bus.count), 64'd4);
    check("fill_overflow", 64'(bus.overflow), 64'd1);
    check("fill_pndng", 64'(bus.pndng_i_in), 64'd1);
    check("fill_head", 64'(bus.data_out_i_in), 64'h00_03_000100);
    // Back-to-back drain, one packet per cycle
    bus.popin = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.popin = 1'b0;
    check("drain_sent", 64'(bus.sent_cnt), 64'd5);
    check("drain_count", 64'(bus.count), 64'd0);
    check("drain_pndng", 64'(bus.pndng_i_in), 64'd0);
    check("drain_full", 64'(bus.full), 64'd0);

    // Reset mid-traffic discards queued entries and clears sticky state
    do_push(4'd5, 4'd6, 1'b1, 23'h7ABCD, 1'b1, 1'b0);
    do_push(4'd7, 4'd8, 1'b0, 23'h01234, 1'b1, 1'b0);
    check("pre_rst_pndng", 64'(bus.pndng_i_in), 64'd1);
    reset = 1'b1;
    exp_q.delete();
    #1;
    check("mid_rst_pndng", 64'(bus.pndng_i_in), 64'd0);
    check("mid_rst_data", 64'(bus.data_out_i_in), 64'd0);
    check("mid_rst_count", 64'(bus.count), 64'd0);
    check("mid_rst_overflow", 64'(bus.overflow), 64'd0);
    check("mid_rst_sent", 64'(bus.sent_cnt), 64'd0);
    #149 reset = 1'b0;
    @(posedge clk); #1;
    check("post_rst_pndng", 64'(bus.pndng_i_in), 64'd0);
    check("post_rst_count", 64'(bus.count), 64'd0);

    // Full queue with push and popin in the same cycle
    for (int i = 0; i < 4; i++) begin
      do_push(4'(8 + i), 4'(i), 1'b1, 23'(23'h200 + i), 1'b1, 1'b0);
    end
    do_push(4'd15, 4'd15, 1'b0, 23'h7FFFFF, 1'b1, 1'b1);
    check("fullpop_count", 64'(bus.count), 64'd4);
    check("fullpop_full", 64'(bus.full), 64'd1);
    check("fullpop_overflow", 64'(bus.overflow), 64'd0);
    check("fullpop_sent", 64'(bus.sent_cnt), 64'd1);
    bus.popin = 1'b1;
    repeat (4) @(posedge clk);
    #1 bus.popin = 1'b0;
    check("fullpop_drain_sent", 64'(bus.sent_cnt), 64'd5);
    check("fullpop_drain_count", 64'(bus.count), 64'd0);

    // Push and popin on the last entry: new entry presented without a bubble
    do_push(4'd1, 4'd2, 1'b0, 23'h000AAA, 1'b1, 1'b0);
    @(posedge clk); #1;
    check("last_pndng", 64'(bus.pndng_i_in), 64'd1);
    do_push(4'd2, 4'd1, 1'b1, 23'h000555, 1'b1, 1'b1);
    check("last_pndng_hold", 64'(bus.pndng_i_in), 64'd1);
    check("last_count", 64'(bus.count), 64'd1);
    check("last_data", 64'(bus.data_out_i_in), 64'h00_21_800555);
    bus.popin = 1'b1;
    @(posedge clk); #1;
    bus.popin = 1'b0;
    check("last_sent", 64'(bus.sent_cnt), 64'd7);
    check("last_done_pndng", 64'(bus.pndng_i_in), 64'd0);

    // popin while idle is ignored
    bus.popin = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.popin = 1'b0;
    check("idle_pop_sent", 64'(bus.sent_cnt), 64'd7);
    check("idle_pop_pndng", 64'(bus.pndng_i_in), 64'd0);

    // Gap instance: two packets, popin held high, valid must drop for exactly 3 cycles
    pa = pkt(4'd3, 4'd0, 1'b1, 23'h00C0DE);
    pb = pkt(4'd0, 4'd2, 1'b0, 23'h00BEEF);
    gbus.push = 1'b1; gbus.in_row = 4'd3; gbus.in_col = 4'd0; gbus.in_mode = 1'b1;
    gbus.in_payload = 23'h00C0DE;
    @(posedge clk); #1;
    gbus.in_row = 4'd0; gbus.in_col = 4'd2; gbus.in_mode = 1'b0; gbus.in_payload = 23'h00BEEF;
    @(posedge clk); #1;
    gbus.push = 1'b0;
    check("gap_first_pndng", 64'(gbus.pndng_i_in), 64'd1);
    check("gap_first_data", 64'(gbus.data_out_i_in), 64'(pa));
    gbus.popin = 1'b1;
    zeros = 0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(posedge clk); #1;
      if (gbus.pndng_i_in) seen = 1'b1;
      else zeros++;
    end
    gbus.popin = 1'b0;
    check("gap_second_seen", 64'(seen), 64'd1);
    check("gap_len", 64'(zeros), 64'd3);
    check("gap_second_data", 64'(gbus.data_out_i_in), 64'(pb));
    check("gap_sent1", 64'(gbus.sent_cnt), 64'd1);
    gbus.popin = 1'b1;
    @(posedge clk); #1;
    gbus.popin = 1'b0;
    check("gap_sent2", 64'(gbus.sent_cnt), 64'd2);
    check("gap_end_pndng", 64'(gbus.pndng_i_in), 64'd0);
    check("gap_end_count", 64'(gbus.count), 64'd0);

    repeat (2) @(posedge clk);
    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
